// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, initial hash value, bit functions and FSM state type.
package sha256_pkg;

    typedef logic [7:0][31:0] words_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam words_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; word 7 is a, word 0 is h.
module sha256_round
    import sha256_pkg::*;
(
    input  words_t      v_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output words_t      v_o
);

    logic [31:0] t1, t2;

    assign t1  = v_i[0] + S1(v_i[3]) + ch(v_i[3], v_i[2], v_i[1]) + k_i + w_i;
    assign t2  = S0(v_i[7]) + maj(v_i[7], v_i[6], v_i[5]);
    assign v_o = {t1 + t2, v_i[7], v_i[6], v_i[5], v_i[4] + t1, v_i[3], v_i[2], v_i[1]};

endmodule

// File: rtl/sha256_compress_iter.sv
// sha256_compress_iter: iterative SHA-256 compression, one round per clock,
// message schedule generated in a 16-word sliding window.
module sha256_compress_iter
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    localparam int CW = NUM_ROUNDS > 1 ? $clog2(NUM_ROUNDS) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     t_q, t_d;
    logic [0:15][31:0] w_q, w_d;
    words_t            v_q, v_d, h_q, h_d, hash_q, hash_d, v_nxt;
    logic              done_q, done_d;
    logic [31:0]       w_new;

    sha256_round u_round (.v_i(v_q), .w_i(w_q[0]), .k_i(K[t_q]), .v_o(v_nxt));

    assign w_new    = s1(w_q[14]) + w_q[9] + s0(w_q[1]) + w_q[0];
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign hash_out = hash_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        v_d     = v_q;
        h_d     = h_q;
        hash_d  = hash_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                w_d     = block_in;
                h_d     = hash_in;
                v_d     = hash_in;
                t_d     = '0;
                state_d = ROUND;
            end
            ROUND: begin
                v_d     = v_nxt;
                w_d     = {w_q[1:15], w_new};
                t_d     = (t_q == CW'(NUM_ROUNDS - 1)) ? t_q : t_q + 1'b1;
                state_d = (t_q == CW'(NUM_ROUNDS - 1)) ? FINAL : ROUND;
            end
            default: begin
                for (int i = 0; i < 8; i++) hash_d[i] = h_q[i] + v_q[i];
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            w_q     <= '0;
            v_q     <= '0;
            h_q     <= '0;
            hash_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
            v_q     <= v_d;
            h_q     <= h_d;
            hash_q  <= hash_d;
            done_q  <= done_d;
        end
    end

endmodule
